// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock, through a single
// full-subtractor cell and borrow flop. The result is held until the next operation completes.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic br_q, br_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic borrow_q, borrow_d, ovf_q, ovf_d;

  logic a0, b0, d_bit, br_next;

  assign a0      = a_sh_q[0];
  assign b0      = b_sh_q[0];
  assign d_bit   = a0 ^ b0 ^ br_q;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // Each difference bit enters at the MSB so bit i lands at position i after WIDTH shifts.
        res_d  = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
        br_d   = br_next;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          diff_d   = res_d;
          borrow_d = br_next;
          // d_bit is the result MSB on the final shift.
          ovf_d    = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: an 8-bit and a 1-bit instance share clock and reset.
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start8, busy8, done8, borrow8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start1, busy1, done1, borrow1, ovf1;
  logic [0:0] a1, b1, diff1;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
  );

  serial_sub #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .ovf(ovf1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec8_t;

  typedef struct {
    logic [0:0] a;
    logic [0:0] b;
    logic [0:0] diff;
    logic       borrow;
    logic       ovf;
  } vec1_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one 8-bit op from IDLE; lat = negedges after the accepting edge until done (0 = none).
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    start8 = 1'b1;
    a8     = av;
    b8     = bv;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start8 = 1'b0;
        a8     = 8'hC3;
        b8     = 8'h3C;
      end
      if (busy8) nbusy++;
      if (done8) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic op1(input logic [0:0] av, input logic [0:0] bv, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    start1 = 1'b1;
    a1     = av;
    b1     = bv;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start1 = 1'b0;
      if (busy1) nbusy++;
      if (done1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    vec8_t v8[7];
    vec1_t v1[4];
    int    lat, nbusy, ndone, last, pulses;
    logic [7:0] seen_diff;

    v8[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    v8[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    v8[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    v8[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    v8[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    v8[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    v8[6] = '{8'h3C, 8'h0F, 8'h2D, 1'b0, 1'b0};

    v1[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    v1[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    v1[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v1[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0;
    start8  = 1'b0;
    a8      = '0;
    b8      = '0;
    start1  = 1'b0;
    a1      = '0;
    b1      = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_diff8", diff8, 0);
    chk("rst_borrow8", borrow8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_busy1", busy1, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      op8(v8[i].a, v8[i].b, lat, nbusy);
      chk($sformatf("lat8[%0d]", i), lat, 9);
      chk($sformatf("busy8[%0d]", i), nbusy, 8);
      chk($sformatf("diff8[%0d]", i), diff8, v8[i].diff);
      chk($sformatf("borrow8[%0d]", i), borrow8, v8[i].borrow);
      chk($sformatf("ovf8[%0d]", i), ovf8, v8[i].ovf);
    end

    // start during RUN must be ignored, not queued
    @(negedge clk);
    start8 = 1'b1;
    a8     = 8'h10;
    b8     = 8'h01;
    ndone  = 0;
    seen_diff = '0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) start8 = 1'b0;
      if (n == 3) begin
        start8 = 1'b1;
        a8     = 8'hAA;
        b8     = 8'h55;
      end
      if (n == 4) start8 = 1'b0;
      if (done8) begin
        ndone++;
        seen_diff = diff8;
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_diff", seen_diff, 8'h0F);

    // reset in RUN cycle 4 discards the op
    @(negedge clk);
    start8 = 1'b1;
    a8     = 8'h20;
    b8     = 8'h01;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) start8 = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rr_busy", busy8, 0);
    chk("rr_done", done8, 0);
    chk("rr_diff", diff8, 0);
    chk("rr_borrow", borrow8, 0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("rr_quiet", ndone, 0);
    op8(8'h20, 8'h01, lat, nbusy);
    chk("rr_fresh_lat", lat, 9);
    chk("rr_fresh_diff", diff8, 8'h1F);

    // start held high: back-to-back ops every WIDTH+2 cycles
    @(negedge clk);
    start8 = 1'b1;
    a8     = 8'h09;
    b8     = 8'h04;
    last   = -1;
    pulses = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done8) begin
        pulses++;
        if (last >= 0) chk("hold_spacing", n - last, 10);
        last = n;
      end
      if (last >= 0) chk("hold_diff", diff8, 8'h05);
    end
    chk("hold_pulses", pulses, 4);
    start8 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done8) begin
        lat = n;
        break;
      end
    end
    chk("hold_drain", lat != 0, 1);

    for (int i = 0; i < 4; i++) begin
      op1(v1[i].a, v1[i].b, lat, nbusy);
      chk($sformatf("lat1[%0d]", i), lat, 2);
      chk($sformatf("busy1[%0d]", i), nbusy, 1);
      chk($sformatf("diff1[%0d]", i), diff1, v1[i].diff);
      chk($sformatf("borrow1[%0d]", i), borrow1, v1[i].borrow);
      chk($sformatf("ovf1[%0d]", i), ovf1, v1[i].ovf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
